// File: rtl/uart_rx_fifo_if.sv
// Consumer-side interface of the UART receiver: FIFO read port, status and error flags.
// The receiver uses the slave modport; the polling consumer uses master.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                 rd_en;
  logic                 clear_err;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_perr;
  logic                 rd_valid;
  logic [CntW-1:0]      fifo_count;
  logic                 cts;
  logic                 frame_err;
  logic                 overflow;

  modport slave (
    input  rd_en, clear_err,
    output rd_data, rd_perr, rd_valid, fifo_count, cts, frame_err, overflow
  );

  modport master (
    output rd_en, clear_err,
    input  rd_data, rd_perr, rd_valid, fifo_count, cts, frame_err, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver (data width, parity, stop bits) feeding a show-ahead FIFO
// with sticky overflow and registered CTS flow control.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CTS_THRESH   = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          serial_i,
  uart_rx_fifo_if.slave rd_if
);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = AW + 1;
  localparam int unsigned TW   = $clog2(CLKS_PER_BIT);

  typedef logic [TW-1:0] tick_t;
  localparam tick_t HalfBit = tick_t'(CLKS_PER_BIT / 2 - 1);
  localparam tick_t FullBit = tick_t'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitHigh} state_e;

  logic sync1_q, rx_q, rx_prev_q;

  state_e               state_q, state_d;
  tick_t                tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 push_q, push_d;
  logic                 frame_err_q, frame_err_d;
  logic                 stop_bad;

  logic [DATA_BITS:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 cts_q;
  logic                 full, empty, pop, wr, drop;
  logic [DATA_BITS:0]   head;

  // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b1;
      rx_q      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= serial_i;
      rx_q      <= sync1_q;
      rx_prev_q <= rx_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      tick_q      <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      perr_q      <= 1'b0;
      stop_bad_q  <= 1'b0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      perr_q      <= perr_d;
      stop_bad_q  <= stop_bad_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    data_d      = data_q;
    perr_d      = perr_q;
    stop_bad_d  = stop_bad_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    stop_bad    = stop_bad_q | ~rx_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_q && rx_prev_q) begin
          state_d = StStart;
          tick_d  = HalfBit;
        end
      end
      StStart: begin
        if (tick_q == '0) begin
          if (rx_q) begin
            state_d = StIdle;
          end else begin
            state_d    = StData;
            tick_d     = FullBit;
            bit_d      = '0;
            perr_d     = 1'b0;
            stop_bad_d = 1'b0;
          end
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      StData: begin
        if (tick_q == '0) begin
          tick_d = FullBit;
          data_d = {rx_q, data_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_MODE != 0) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      StParity: begin
        if (tick_q == '0) begin
          tick_d  = FullBit;
          perr_d  = ((^data_q) ^ rx_q) != (PARITY_MODE == 2);
          state_d = StStop;
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      StStop: begin
        if (tick_q == '0) begin
          tick_d     = FullBit;
          stop_bad_d = stop_bad;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            if (stop_bad) begin
              frame_err_d = 1'b1;
              state_d     = StWaitHigh;
            end else begin
              push_d  = 1'b1;
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      // A break holds the line low; re-arm only once it has returned high.
      StWaitHigh: begin
        if (rx_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = rd_if.rd_en & ~empty;
  assign wr    = push_q & (~full | pop);
  assign drop  = push_q & full & ~pop;

  always_comb begin
    count_d = count_q;
    unique case ({wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
    end else if (rd_if.clear_err) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= {perr_q, data_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cts_q      <= 1'b1;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cts_q      <= (count_q < CntW'(CTS_THRESH));
    end
  end

  // Head is gated so the outputs read zero while empty, including straight after reset.
  assign head             = mem_q[rd_ptr_q];
  assign rd_if.rd_valid   = ~empty;
  assign rd_if.rd_data    = empty ? '0 : head[DATA_BITS-1:0];
  assign rd_if.rd_perr    = empty ? 1'b0 : head[DATA_BITS];
  assign rd_if.fifo_count = count_q;
  assign rd_if.cts        = cts_q;
  assign rd_if.frame_err  = frame_err_q;
  assign rd_if.overflow   = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: even parity, 1 stop bit, 4-entry FIFO, scoreboard of words.
module tb_uart_rx_fifo;
  localparam int unsigned Cpb = 16;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic serial = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   fe_cnt = 0;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus ();

  uart_rx_fifo #(
    .CLKS_PER_BIT(Cpb),
    .DATA_BITS   (8),
    .PARITY_MODE (1),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (4),
    .CTS_THRESH  (3)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .serial_i(serial),
    .rd_if   (bus)
  );

  always @(negedge clk) if (bus.frame_err === 1'b1) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    serial = b;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pbit);
    send_bit(stopb);
  endtask

  // Even parity: the receiver flags an error when data and parity bit have odd weight.
  task automatic send_word(input logic [7:0] d, input logic pbit, input logic store);
    if (store) sb.push_back({(^d) ^ pbit, d});
    send_frame(d, pbit, 1'b1);
  endtask

  task automatic send_good(input logic [7:0] d, input logic store);
    send_word(d, ^d, store);
    serial = 1'b1;
    idle(Cpb);
  endtask

  task automatic read_check(input string tag);
    logic [8:0] exp;
    int n = 0;
    while (bus.rd_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, 32'(bus.rd_valid), 32'd1);
    exp = (sb.size() != 0) ? sb.pop_front() : 9'bx;
    check({tag, " data"}, 32'(bus.rd_data), 32'(exp[7:0]));
    check({tag, " perr"}, 32'(bus.rd_perr), 32'(exp[8]));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " rd_valid"},   32'(bus.rd_valid),   32'd0);
    check({tag, " rd_data"},    32'(bus.rd_data),    32'd0);
    check({tag, " rd_perr"},    32'(bus.rd_perr),    32'd0);
    check({tag, " fifo_count"}, 32'(bus.fifo_count), 32'd0);
    check({tag, " cts"},        32'(bus.cts),        32'd1);
    check({tag, " frame_err"},  32'(bus.frame_err),  32'd0);
    check({tag, " overflow"},   32'(bus.overflow),   32'd0);
  endtask

  initial begin
    int n;
    bus.rd_en     = 1'b0;
    bus.clear_err = 1'b0;
    idle(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    idle(5);

    // 1: clean word, then pop empties the FIFO
    send_good(8'hA5, 1'b1);
    check("t1 count", 32'(bus.fifo_count), 32'd1);
    read_check("t1");
    check("t1 empty", 32'(bus.rd_valid), 32'd0);

    // 2: wrong parity bit is stored with the word
    send_word(8'h3C, 1'b1, 1'b1);
    serial = 1'b1;
    idle(Cpb);
    read_check("t2");
    check("t2 frame_err", 32'(fe_cnt), 32'd0);
    check("t2 overflow", 32'(bus.overflow), 32'd0);

    // 3: low stop bit followed by a long break
    send_frame(8'h55, 1'b0, 1'b0);
    idle(300);
    check("t3 fe pulse", 32'(fe_cnt), 32'd1);
    check("t3 count", 32'(bus.fifo_count), 32'd0);
    serial = 1'b1;
    idle(2 * Cpb);
    check("t3 no restart", 32'(fe_cnt), 32'd1);
    check("t3 empty", 32'(bus.rd_valid), 32'd0);

    // 4: fill, overflow, drain, clear
    send_good(8'h01, 1'b1);
    send_good(8'h02, 1'b1);
    check("t4 cts at 2", 32'(bus.cts), 32'd1);
    send_good(8'h03, 1'b1);
    check("t4 cts at 3", 32'(bus.cts), 32'd0);
    send_good(8'h04, 1'b1);
    check("t4 count 4", 32'(bus.fifo_count), 32'd4);
    check("t4 no ovf yet", 32'(bus.overflow), 32'd0);
    send_good(8'h05, 1'b0);
    check("t4 overflow", 32'(bus.overflow), 32'd1);
    check("t4 count held", 32'(bus.fifo_count), 32'd4);
    for (int i = 0; i < 4; i++) read_check("t4 rd");
    idle(2);
    check("t4 drained", 32'(bus.rd_valid), 32'd0);
    check("t4 cts back", 32'(bus.cts), 32'd1);
    check("t4 ovf sticky", 32'(bus.overflow), 32'd1);
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    check("t4 ovf cleared", 32'(bus.overflow), 32'd0);

    // 5: short low glitch on an idle line
    serial = 1'b0;
    idle(4);
    serial = 1'b1;
    idle(3 * Cpb);
    check("t5 count", 32'(bus.fifo_count), 32'd0);
    check("t5 fe", 32'(fe_cnt), 32'd1);
    check("t5 ovf", 32'(bus.overflow), 32'd0);
    send_good(8'h5A, 1'b1);
    read_check("t5 after");

    // 6: reset mid-frame with a word buffered
    send_good(8'h11, 1'b1);
    check("t6 count pre", 32'(bus.fifo_count), 32'd1);
    send_bit(1'b0);
    serial = 1'b1;
    idle(40);
    rst_n = 1'b0;
    idle(2);
    check_reset_vals("t6 reset");
    sb.delete();
    rst_n = 1'b1;
    idle(200);
    check("t6 no partial", 32'(bus.fifo_count), 32'd0);
    check("t6 no fe", 32'(fe_cnt), 32'd1);
    send_good(8'h81, 1'b1);
    read_check("t6 rx");

    // Full FIFO with a pop landing on the write cycle
    for (int i = 0; i < 4; i++) send_good(8'(8'h10 + i), 1'b1);
    check("t7 full", 32'(bus.fifo_count), 32'd4);
    n = 0;
    fork
      send_good(8'h14, 1'b1);
      begin
        while (dut.push_q !== 1'b1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        read_check("t7 coincide");
      end
    join
    check("t7 push seen", 32'(n < 400), 32'd1);
    check("t7 count", 32'(bus.fifo_count), 32'd4);
    check("t7 no ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) read_check("t7 rd");
    check("t7 empty", 32'(bus.rd_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
